rs_dsp_multacc_mc: RTL and testbench
====================================

Name: rs_dsp_multacc_mc

Overview:
- Parametrised, multi-channel successor of the single multiply-accumulate DSP block.
- One shared signed/unsigned multiplier feeds a bank of CHANNELS independent accumulators, selected per input beat.
- Valid/ready handshakes on input and output; two-stage pipeline with same-channel bypass.
- Post-accumulate shift-right, round and saturate stage on the output.

Parameters:
- A_WIDTH, 20, multiplicand a width
- B_WIDTH, 18, multiplier b width
- ACC_WIDTH, 48, accumulator width; must be >= A_WIDTH+B_WIDTH
- Z_WIDTH, 38, output width; must be <= ACC_WIDTH
- CHANNELS, 4, number of accumulators; >= 2
- CH_W, $clog2(CHANNELS), channel index width (derived)

Ports:
- clk  in  1  clock
- lreset  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- a  in  A_WIDTH  multiplicand
- b  in  B_WIDTH  multiplier
- ch  in  CH_W  target accumulator
- unsigned_a  in  1  1 = a unsigned, 0 = a two's complement
- unsigned_b  in  1  1 = b unsigned, 0 = b two's complement
- load_acc  in  1  1 = discard stored value (acc := ±product)
- subtract  in  1  1 = acc - product, 0 = acc + product
- shift_right  in  6  output arithmetic right shift amount
- round  in  1  round-half-up before shift
- saturate_enable  in  1  saturate output to Z_WIDTH signed range
- out_valid  out  1  z/out_ch valid
- out_ready  in  1  sink accepts output
- z  out  Z_WIDTH  post-processed accumulator value
- out_ch  out  CH_W  channel of z
- overflow  out  1  saturation or truncation occurred on this output beat

Behaviour:
- Reset: all accumulators 0, pipeline empty, out_valid=0, z=0, out_ch=0, overflow=0, in_ready=1 in the cycle after reset deasserts. Reset mid-operation drops all in-flight beats with no output.
- Accept: beat taken when in_valid && in_ready. All control fields (ch, unsigned_*, load_acc, subtract, shift_right, round, saturate_enable) are captured with a/b and travel with the beat.
- Stage 1 (P1): product = ext(a) * ext(b), each operand extended to width+1 (zero-extended if its unsigned flag is set, else sign-extended), then sign-extended to ACC_WIDTH.
- Stage 2 (P2):
  - base = load_acc ? 0 : acc[ch].
  - sum = subtract ? base - product : base + product, modulo 2^ACC_WIDTH (wraps, no accumulator saturation).
  - acc[ch] := sum, written when the beat leaves P2.
- Bypass: if the beat in P2 targets the same ch as the beat in P1, the P1 beat uses the P2 sum as base. Back-to-back same-channel beats must equal sequential execution.
- Output, computed from sum when the beat enters the output register:
  - r = round && shift_right>0 ? sum + 2^(shift_right-1) : sum, evaluated at ACC_WIDTH+1 bits.
  - s = r >>> shift_right; shift_right >= ACC_WIDTH yields all sign bits.
  - Saturate enabled: if s exceeds the signed Z_WIDTH range, z = max or min and overflow=1.
  - Saturate disabled: z = s[Z_WIDTH-1:0]; overflow=1 if the discarded upper bits are not a sign extension.
- Latency: accepted beat appears at out_valid exactly 2 cycles later when unstalled. Throughput is 1 beat/cycle.
- Backpressure:
  - out_valid && !out_ready holds z/out_ch/overflow stable and stalls P1/P2.
  - in_ready = !(out_valid && !out_ready) || pipeline has a bubble ahead.
  - Accumulator writes happen only on the P2 advance, so a stall never double-accumulates.
- Simultaneous in-accept and output-accept in the same cycle are both legal.
- Beats on different channels do not interact.

Optional Feature:
- Macro: RS_DSP_MULTACC_MC_CLEAR_EN.
- Defined:
  - Adds input port clear_all (1 bit).
  - When 1 in a cycle, all accumulators become 0 at the next edge.
  - A beat in P2 in that cycle still emits its output, but its write is suppressed.
  - Bypass to P1 is also suppressed, so P1 sees base 0.
- Undefined: port absent; accumulators are cleared only by lreset or load_acc.

Test Plan:
- Signed basic: ch0 beats a=3,b=5 then a=-2,b=7, all controls 0 -> z=15 then z=1, out_ch=0, each arriving 2 cycles after accept.
- Bypass/interleave: back-to-back ch1 a=100,b=100 ×3 interleaved with ch2 a=1,b=1 -> ch1 outputs 10000, 20000, 30000; ch2 outputs 1, 2, …; no cross-talk.
- Unsigned/load/subtract: unsigned_a=1, a=20'hFFFFF, b=1, load_acc=1 -> z=1048575; next beat subtract=1, a=1, b=1 -> z=1048574.
- Shift/round/saturate:
  - acc=7, shift_right=1, round=1 -> z=4; round=0 -> z=3.
  - acc=2^40 with saturate_enable=1 -> z=2^37-1, overflow=1.
  - acc=2^40 with saturate_enable=0 -> z=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops, z stable, no beats lost or duplicated; final accumulator matches the reference sum.
- Reset mid-stream: assert lreset with 2 beats in flight -> no out_valid, and the next ch0 a=1,b=1 gives z=1.

Source files
------------

// File: rtl/rs_dsp_multacc_mc.sv
// rs_dsp_multacc_mc: shared multiplier feeding CHANNELS accumulators,
// with shift-right, round and saturate applied to each output beat.
//
// Ports:
//   clk, lreset        clock; synchronous active-high reset
//   in_valid/in_ready  input beat handshake; a, b, ch and the control
//                      fields (unsigned_a/b, load_acc, subtract,
//                      shift_right, round, saturate_enable) travel with it
//   out_valid/out_ready output handshake for z, out_ch, overflow
//   clear_all          only when RS_DSP_MULTACC_MC_CLEAR_EN is defined:
//                      zero every accumulator at the next edge
//
// Pipeline: P1 holds the accepted beat and computes the product, the
// accumulate and the post-processing; P2 is the output register.
// A beat writes its accumulator when it leaves P2, and a same-channel
// beat in P1 takes its base from the P2 sum, so back-to-back beats
// behave exactly like sequential execution.
module rs_dsp_multacc_mc #(
   parameter int A_WIDTH   = 20,
   parameter int B_WIDTH   = 18,
   parameter int ACC_WIDTH = 48,
   parameter int Z_WIDTH   = 38,
   parameter int CHANNELS  = 4,
   parameter int CH_W      = $clog2(CHANNELS)
) (
   input  logic                 clk,
   input  logic                 lreset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   input  logic [CH_W-1:0]      ch,
   input  logic                 unsigned_a,
   input  logic                 unsigned_b,
   input  logic                 load_acc,
   input  logic                 subtract,
   input  logic [5:0]           shift_right,
   input  logic                 round,
   input  logic                 saturate_enable,
`ifdef RS_DSP_MULTACC_MC_CLEAR_EN
   input  logic                 clear_all,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [Z_WIDTH-1:0]   z,
   output logic [CH_W-1:0]      out_ch,
   output logic                 overflow
);

   // Full product width of the two width+1 extended operands.
   localparam int PW = A_WIDTH + B_WIDTH + 2;
   localparam int XW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

   logic clr_all;
`ifdef RS_DSP_MULTACC_MC_CLEAR_EN
   assign clr_all = clear_all;
`else
   assign clr_all = 1'b0;
`endif

   // P1 stage registers
   logic                 p1_valid_q, p1_valid_d;
   logic [A_WIDTH-1:0]   p1_a_q, p1_a_d;
   logic [B_WIDTH-1:0]   p1_b_q, p1_b_d;
   logic [CH_W-1:0]      p1_ch_q, p1_ch_d;
   logic                 p1_ua_q, p1_ua_d;
   logic                 p1_ub_q, p1_ub_d;
   logic                 p1_load_q, p1_load_d;
   logic                 p1_sub_q, p1_sub_d;
   logic [5:0]           p1_sh_q, p1_sh_d;
   logic                 p1_rnd_q, p1_rnd_d;
   logic                 p1_sat_q, p1_sat_d;

   // P2 / output registers
   logic                 p2_valid_q, p2_valid_d;
   logic [ACC_WIDTH-1:0] p2_sum_q, p2_sum_d;
   logic [CH_W-1:0]      p2_ch_q, p2_ch_d;
   logic [Z_WIDTH-1:0]   p2_z_q, p2_z_d;
   logic                 p2_ovf_q, p2_ovf_d;
   // Set when a clear hit while this beat sat in P2: its sum predates
   // the clear, so it must neither write back nor be bypassed.
   logic                 p2_nowr_q, p2_nowr_d;

   logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
   logic [ACC_WIDTH-1:0] acc_d [CHANNELS];

   // Handshake
   logic p2_leave;
   logic p2_free;
   logic p1_adv;
   logic accept;

   assign p2_leave = p2_valid_q && out_ready;
   assign p2_free  = !p2_valid_q || out_ready;
   assign p1_adv   = p1_valid_q && p2_free;
   assign in_ready = !p1_valid_q || p2_free;
   assign accept   = in_valid && in_ready;

   // Datapath
   logic signed [A_WIDTH:0]     a_ext;
   logic signed [B_WIDTH:0]     b_ext;
   logic signed [PW-1:0]        prod_full;
   logic signed [XW-1:0]        prod_x;
   logic [ACC_WIDTH-1:0]        product;
   logic                        bypass;
   logic [ACC_WIDTH-1:0]        base;
   logic [ACC_WIDTH-1:0]        sum;
   logic signed [ACC_WIDTH:0]   sum_x;
   logic signed [ACC_WIDTH:0]   rnd_add;
   logic signed [ACC_WIDTH:0]   r;
   logic signed [ACC_WIDTH:0]   s;
   logic [ACC_WIDTH:Z_WIDTH-1]  s_top;
   logic                        fits;
   logic [Z_WIDTH-1:0]          z_calc;
   logic                        ovf_calc;

   always_comb begin
      a_ext = {(p1_ua_q ? 1'b0 : p1_a_q[A_WIDTH-1]), p1_a_q};
      b_ext = {(p1_ub_q ? 1'b0 : p1_b_q[B_WIDTH-1]), p1_b_q};
      prod_full = PW'(a_ext) * PW'(b_ext);
      prod_x = XW'(prod_full);
      product = prod_x[ACC_WIDTH-1:0];

      bypass = p2_valid_q && !p2_nowr_q && (p2_ch_q == p1_ch_q);

      if (p1_load_q || clr_all) begin
         base = '0;
      end else if (bypass) begin
         base = p2_sum_q;
      end else begin
         base = acc_q[p1_ch_q];
      end

      sum = p1_sub_q ? (base - product) : (base + product);

      // Round-half-up only while the half-LSB lies inside the sum;
      // larger shifts just return the sign.
      sum_x = {sum[ACC_WIDTH-1], sum};
      rnd_add = '0;
      if (p1_rnd_q && (p1_sh_q != 6'd0) &&
          (int'(p1_sh_q) <= ACC_WIDTH)) begin
         rnd_add = (ACC_WIDTH+1)'(1) << (p1_sh_q - 6'd1);
      end
      r = sum_x + rnd_add;
      s = r >>> p1_sh_q;

      s_top = s[ACC_WIDTH:Z_WIDTH-1];
      fits = (&s_top) || !(|s_top);
      ovf_calc = !fits;
      if (!fits && p1_sat_q) begin
         z_calc = s[ACC_WIDTH] ? {1'b1, {(Z_WIDTH-1){1'b0}}}
                               : {1'b0, {(Z_WIDTH-1){1'b1}}};
      end else begin
         z_calc = s[Z_WIDTH-1:0];
      end
   end

   // Next state
   always_comb begin
      p1_valid_d = p1_valid_q;
      p1_a_d     = p1_a_q;
      p1_b_d     = p1_b_q;
      p1_ch_d    = p1_ch_q;
      p1_ua_d    = p1_ua_q;
      p1_ub_d    = p1_ub_q;
      p1_load_d  = p1_load_q;
      p1_sub_d   = p1_sub_q;
      p1_sh_d    = p1_sh_q;
      p1_rnd_d   = p1_rnd_q;
      p1_sat_d   = p1_sat_q;

      p2_valid_d = p2_valid_q;
      p2_sum_d   = p2_sum_q;
      p2_ch_d    = p2_ch_q;
      p2_z_d     = p2_z_q;
      p2_ovf_d   = p2_ovf_q;
      p2_nowr_d  = p2_nowr_q | clr_all;

      acc_d = acc_q;

      if (accept) begin
         p1_valid_d = 1'b1;
         p1_a_d     = a;
         p1_b_d     = b;
         p1_ch_d    = ch;
         p1_ua_d    = unsigned_a;
         p1_ub_d    = unsigned_b;
         p1_load_d  = load_acc;
         p1_sub_d   = subtract;
         p1_sh_d    = shift_right;
         p1_rnd_d   = round;
         p1_sat_d   = saturate_enable;
      end else if (p1_adv) begin
         p1_valid_d = 1'b0;
      end

      if (p1_adv) begin
         p2_valid_d = 1'b1;
         p2_sum_d   = sum;
         p2_ch_d    = p1_ch_q;
         p2_z_d     = z_calc;
         p2_ovf_d   = ovf_calc;
         // Its base already reflects any clear in this cycle.
         p2_nowr_d  = 1'b0;
      end else if (p2_leave) begin
         p2_valid_d = 1'b0;
      end

      if (clr_all) begin
         for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = '0;
         end
      end else if (p2_leave && !p2_nowr_q) begin
         acc_d[p2_ch_q] = p2_sum_q;
      end
   end

   always_ff @(posedge clk) begin
      if (lreset) begin
         p1_valid_q <= 1'b0;
         p1_a_q     <= '0;
         p1_b_q     <= '0;
         p1_ch_q    <= '0;
         p1_ua_q    <= 1'b0;
         p1_ub_q    <= 1'b0;
         p1_load_q  <= 1'b0;
         p1_sub_q   <= 1'b0;
         p1_sh_q    <= '0;
         p1_rnd_q   <= 1'b0;
         p1_sat_q   <= 1'b0;
         p2_valid_q <= 1'b0;
         p2_sum_q   <= '0;
         p2_ch_q    <= '0;
         p2_z_q     <= '0;
         p2_ovf_q   <= 1'b0;
         p2_nowr_q  <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         p1_valid_q <= p1_valid_d;
         p1_a_q     <= p1_a_d;
         p1_b_q     <= p1_b_d;
         p1_ch_q    <= p1_ch_d;
         p1_ua_q    <= p1_ua_d;
         p1_ub_q    <= p1_ub_d;
         p1_load_q  <= p1_load_d;
         p1_sub_q   <= p1_sub_d;
         p1_sh_q    <= p1_sh_d;
         p1_rnd_q   <= p1_rnd_d;
         p1_sat_q   <= p1_sat_d;
         p2_valid_q <= p2_valid_d;
         p2_sum_q   <= p2_sum_d;
         p2_ch_q    <= p2_ch_d;
         p2_z_q     <= p2_z_d;
         p2_ovf_q   <= p2_ovf_d;
         p2_nowr_q  <= p2_nowr_d;
         for (int i = 0; i < CHANNELS; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign out_valid = p2_valid_q;
   assign z         = p2_z_q;
   assign out_ch    = p2_ch_q;
   assign overflow  = p2_ovf_q;

endmodule

// File: tb/tb_rs_dsp_multacc_mc.sv
// Bench for rs_dsp_multacc_mc: directed steps plus random traffic,
// checked against a sequential accumulate-and-postprocess model.
module tb_rs_dsp_multacc_mc;

   localparam longint ZMAX  = (64'sd1 <<< 37) - 1;
   localparam longint ZMIN  = -(64'sd1 <<< 37);
   localparam longint ZMASK = (64'sd1 <<< 38) - 1;

   logic        clk = 1'b0;
   logic        lreset;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] a;
   logic [17:0] b;
   logic [1:0]  ch;
   logic        unsigned_a;
   logic        unsigned_b;
   logic        load_acc;
   logic        subtract;
   logic [5:0]  shift_right;
   logic        round;
   logic        saturate_enable;
   logic        out_valid;
   logic        out_ready;
   logic [37:0] z;
   logic [1:0]  out_ch;
   logic        overflow;

   always #5 clk = ~clk;

   rs_dsp_multacc_mc dut (
      .clk             (clk),
      .lreset          (lreset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .a               (a),
      .b               (b),
      .ch              (ch),
      .unsigned_a      (unsigned_a),
      .unsigned_b      (unsigned_b),
      .load_acc        (load_acc),
      .subtract        (subtract),
      .shift_right     (shift_right),
      .round           (round),
      .saturate_enable (saturate_enable),
`ifdef RS_DSP_MULTACC_MC_CLEAR_EN
      .clear_all       (1'b0),
`endif
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .z               (z),
      .out_ch          (out_ch),
      .overflow        (overflow)
   );

   typedef struct {
      longint z;
      longint ch;
      longint ovf;
      longint t;
   } exp_t;

   exp_t   q[$];
   longint acc_m [4];
   longint fz[$];
   longint fo[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   longint cyc = 0;
   bit     last_acc;
   bit     chk_lat;
   bit     prev_stall;
   bit     saw_block;
   logic [37:0] hz;
   logic [1:0]  hch;
   logic        hovf;

   task automatic chk(input string tag, input longint obs,
                      input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction

   // Sequential reference: one beat at a time, plain integer arithmetic.
   task automatic model_accept();
      longint av, bv, prod, base, sum, rd, r, s, zv;
      exp_t   e;
      int     sh;
      av = unsigned_a ? longint'(a) : sx(longint'(a), 20);
      bv = unsigned_b ? longint'(b) : sx(longint'(b), 18);
      prod = av * bv;
      base = load_acc ? 0 : acc_m[ch];
      sum = sx(subtract ? base - prod : base + prod, 48);
      acc_m[ch] = sum;
      sh = int'(shift_right);
      rd = (round && sh > 0 && sh <= 48) ? (64'sd1 <<< (sh - 1)) : 0;
      r = sum + rd;
      s = r >>> sh;
      e.ovf = (s > ZMAX || s < ZMIN) ? 1 : 0;
      zv = s;
      if (e.ovf == 1 && saturate_enable) zv = (s > 0) ? ZMAX : ZMIN;
      e.z = zv & ZMASK;
      e.ch = longint'(ch);
      e.t = cyc;
      q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      chk("out_expected", longint'(q.size() > 0), 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("z", longint'(z), e.z);
         chk("out_ch", longint'(out_ch), e.ch);
         chk("overflow", longint'(overflow), e.ovf);
         if (chk_lat) chk("latency", cyc - e.t, 2);
      end
      fz.push_back(longint'(z));
      fo.push_back(longint'(overflow));
   endtask

   task automatic tick();
      @(negedge clk);
      last_acc = 1'b0;
      if (lreset) begin
         q.delete();
         foreach (acc_m[i]) acc_m[i] = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_z", longint'(z), longint'(hz));
            chk("hold_ch", longint'(out_ch), longint'(hch));
            chk("hold_ovf", longint'(overflow), longint'(hovf));
         end
         if (out_valid && out_ready) check_out();
         prev_stall = out_valid && !out_ready;
         hz = z;
         hch = out_ch;
         hovf = overflow;
         if (!in_ready) saw_block = 1'b1;
         if (in_valid && in_ready) begin
            model_accept();
            last_acc = 1'b1;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int c, input logic [19:0] ai,
                         input logic [17:0] bi, input bit ua,
                         input bit ub, input bit ld, input bit sb,
                         input int sh, input bit rd, input bit st);
      in_valid = 1'b1;
      ch = 2'(c);
      a = ai;
      b = bi;
      unsigned_a = ua;
      unsigned_b = ub;
      load_acc = ld;
      subtract = sb;
      shift_right = 6'(sh);
      round = rd;
      saturate_enable = st;
   endtask

   task automatic set_rand();
      set_in($urandom_range(0, 3), 20'($urandom), 18'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
             1'($urandom), ($urandom_range(0, 3) == 0) ? 0 :
             $urandom_range(0, 63), 1'($urandom), 1'($urandom));
   endtask

   task automatic send(input int c, input logic [19:0] ai,
                       input logic [17:0] bi, input bit ua,
                       input bit ub, input bit ld, input bit sb,
                       input int sh, input bit rd, input bit st);
      set_in(c, ai, bi, ua, ub, ld, sb, sh, rd, st);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (last_acc) break;
      end
      chk("accept_timeout", longint'(last_acc), 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && q.size() != 0; i++) tick();
      chk("drain", longint'(q.size()), 0);
   endtask

   initial begin
      lreset = 1'b1;
      out_ready = 1'b1;
      chk_lat = 1'b1;
      prev_stall = 1'b0;
      saw_block = 1'b0;
      set_in(0, 20'd0, 18'd0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      repeat (3) tick();
      lreset = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_z", longint'(z), 0);
      chk("rst_out_ch", longint'(out_ch), 0);
      chk("rst_overflow", longint'(overflow), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      @(posedge clk);
      #1;

      // Signed basic, with an idle gap to observe latency.
      fz.delete();
      send(0, 20'd3, 18'd5, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_not_early", longint'(out_valid), 0);
      @(posedge clk);
      #1;
      cyc++;
      tick();
      send(0, 20'hFFFFE, 18'd7, 0, 0, 0, 0, 0, 0, 0);
      drain();
      chk("basic_z0", fz[0], 15);
      chk("basic_z1", fz[1], 1);

      // Same-channel bypass and interleave.
      fz.delete();
      send(1, 20'd100, 18'd100, 0, 0, 0, 0, 0, 0, 0);
      send(1, 20'd100, 18'd100, 0, 0, 0, 0, 0, 0, 0);
      send(2, 20'd1, 18'd1, 0, 0, 0, 0, 0, 0, 0);
      send(1, 20'd100, 18'd100, 0, 0, 0, 0, 0, 0, 0);
      send(2, 20'd1, 18'd1, 0, 0, 0, 0, 0, 0, 0);
      send(2, 20'd1, 18'd1, 0, 0, 0, 0, 0, 0, 0);
      drain();
      chk("ilv_ch1_3", fz[3], 30000);
      chk("ilv_ch2_3", fz[5], 3);

      // Unsigned, load, subtract.
      fz.delete();
      send(3, 20'hFFFFF, 18'd1, 1, 0, 1, 0, 0, 0, 0);
      send(3, 20'd1, 18'd1, 0, 0, 0, 1, 0, 0, 0);
      drain();
      chk("uns_load", fz[0], 1048575);
      chk("sub", fz[1], 1048574);

      // Shift, round, saturate, wrap, large shift.
      fz.delete();
      fo.delete();
      send(0, 20'd7, 18'd1, 0, 0, 1, 0, 1, 1, 0);
      send(0, 20'd0, 18'd0, 0, 0, 0, 0, 1, 0, 0);
      send(2, 20'h80000, 18'h20000, 1, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++)
         send(2, 20'h80000, 18'h20000, 1, 1, 0, 0, 0, 0, 0);
      send(2, 20'h80000, 18'h20000, 1, 1, 0, 0, 0, 0, 1);
      send(2, 20'd0, 18'd0, 0, 0, 0, 0, 0, 0, 0);
      send(1, 20'hFFFFB, 18'd1, 0, 0, 1, 0, 55, 0, 0);
      drain();
      chk("round_up", fz[0], 4);
      chk("round_off", fz[1], 3);
      chk("sat_z", fz[17], ZMAX);
      chk("sat_ovf", fo[17], 1);
      chk("trunc_z", fz[18], 0);
      chk("trunc_ovf", fo[18], 1);
      chk("big_shift", fz[19], ZMASK);

      // Backpressure.
      chk_lat = 1'b0;
      out_ready = 1'b0;
      saw_block = 1'b0;
      set_rand();
      for (int i = 0; i < 5; i++) begin
         tick();
         if (last_acc) set_rand();
      end
      chk("bp_in_ready_drop", longint'(saw_block), 1);
      chk("bp_out_held", longint'(out_valid), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && !last_acc; i++) tick();
      drain();
      for (int c = 0; c < 4; c++)
         send(c, 20'd0, 18'd0, 0, 0, 0, 0, 0, 0, 0);
      drain();

      // Random traffic with random backpressure.
      in_valid = 1'b0;
      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid || last_acc) begin
            if ($urandom_range(0, 3) != 0) set_rand();
            else in_valid = 1'b0;
         end
         tick();
      end
      out_ready = 1'b1;
      drain();

      // Reset with two beats in flight.
      out_ready = 1'b0;
      send(0, 20'd9, 18'd9, 0, 0, 0, 0, 0, 0, 0);
      send(0, 20'd9, 18'd9, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      lreset = 1'b1;
      tick();
      lreset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mid_no_out", longint'(out_valid), 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      fz.delete();
      chk_lat = 1'b1;
      send(0, 20'd1, 18'd1, 0, 0, 0, 0, 0, 0, 0);
      drain();
      chk("rst_mid_z", fz.size() > 0 ? fz[0] : -1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
